hash_job_ctrl: RTL

HASH_JOB_CTRL -- requirements
Module: hash_job_ctrl

---
 rtl/hash_pkg.sv | 18 +
 rtl/hash_job_counter.sv | 43 ++++
 rtl/hash_job_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/hash_pkg.sv
// Shared types and default widths for the hash job controller.
package hash_pkg;

  localparam int unsigned INDEX_PTR_DEF = 2;
  localparam int unsigned DATA_SIZE_DEF = 96;
  localparam int unsigned NONCE_W_DEF   = 32;
  localparam int unsigned JOB_W_DEF     = DATA_SIZE_DEF + NONCE_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    WAIT_HASH,
    DONE
  } state_t;

endpackage

// File: rtl/hash_job_counter.sv
// Nonce/entry pointer sequencer with the per-job nonce limit and end-of-range flags.
module hash_job_counter
  import hash_pkg::*;
#(
  parameter int unsigned INDEX_PTR = INDEX_PTR_DEF,
  parameter int unsigned NONCE_W   = NONCE_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [NONCE_W-1:0]   nonce_limit,
  input  logic                 nonce_inc,
  input  logic                 ptr_inc,
  output logic [NONCE_W-1:0]   nonce,
  output logic [INDEX_PTR-1:0] ptr,
  output logic                 last_nonce_c,
  output logic                 last_entry_c
);

  logic [NONCE_W-1:0] limit_q;

  // Increments are only requested below the limit / last entry, so neither counter wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nonce   <= '0;
      ptr     <= '0;
      limit_q <= '0;
    end else if (clear) begin
      nonce   <= '0;
      ptr     <= '0;
      limit_q <= nonce_limit;
    end else if (ptr_inc) begin
      nonce <= '0;
      ptr   <= ptr + INDEX_PTR'(1);
    end else if (nonce_inc) begin
      nonce <= nonce + NONCE_W'(1);
    end
  end

  assign last_nonce_c = (nonce == limit_q);
  assign last_entry_c = (ptr == {INDEX_PTR{1'b1}});

endmodule

// File: rtl/hash_job_ctrl.sv
// Sweeps every block-memory entry over nonces 0..limit, feeding job words to a hash core.
module hash_job_ctrl
  import hash_pkg::*;
#(
  parameter int unsigned INDEX_PTR = INDEX_PTR_DEF,
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned NONCE_W   = NONCE_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic [NONCE_W-1:0]           nonce_limit,
  output logic [INDEX_PTR-1:0]         rd_ptr,
  input  logic [DATA_SIZE-1:0]         entrada,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic [DATA_SIZE+NONCE_W-1:0] bloque_out,
  input  logic                         hash_done,
  input  logic                         hash_match,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [INDEX_PTR-1:0]         found_ptr,
  output logic [NONCE_W-1:0]           found_nonce
);

  state_t               state, state_n;
  logic [DATA_SIZE-1:0] blk_q;
  logic [NONCE_W-1:0]   nonce;
  logic [INDEX_PTR-1:0] ptr;
  logic                 last_nonce_c, last_entry_c;
  logic                 clear_c, load_c, nonce_inc_c, ptr_inc_c, set_found_c;

  hash_job_counter #(
    .INDEX_PTR (INDEX_PTR),
    .NONCE_W   (NONCE_W)
  ) u_counter (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear_c),
    .nonce_limit  (nonce_limit),
    .nonce_inc    (nonce_inc_c),
    .ptr_inc      (ptr_inc_c),
    .nonce        (nonce),
    .ptr          (ptr),
    .last_nonce_c (last_nonce_c),
    .last_entry_c (last_entry_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and datapath strobes; stop overrides everything outside IDLE.
  always_comb begin
    state_n     = state;
    clear_c     = 1'b0;
    load_c      = 1'b0;
    nonce_inc_c = 1'b0;
    ptr_inc_c   = 1'b0;
    set_found_c = 1'b0;
    if (state != IDLE && stop) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            clear_c = 1'b1;
            state_n = FETCH;
          end
        end
        FETCH: state_n = LOAD;
        LOAD: begin
          load_c  = 1'b1;
          state_n = ISSUE;
        end
        ISSUE: begin
          if (blk_valid && blk_ready) state_n = WAIT_HASH;
        end
        WAIT_HASH: begin
          if (hash_done) begin
            if (hash_match) begin
              set_found_c = 1'b1;
              state_n     = DONE;
            end else if (!last_nonce_c) begin
              nonce_inc_c = 1'b1;
              state_n     = ISSUE;
            end else if (!last_entry_c) begin
              ptr_inc_c = 1'b1;
              state_n   = FETCH;
            end else begin
              state_n = DONE;
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Registered status outputs track the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_q       <= '0;
      blk_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_ptr   <= '0;
      found_nonce <= '0;
    end else begin
      blk_valid <= (state_n == ISSUE);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      if (load_c) blk_q <= entrada;
      if (clear_c) begin
        found       <= 1'b0;
        found_ptr   <= '0;
        found_nonce <= '0;
      end else if (set_found_c) begin
        found       <= 1'b1;
        found_ptr   <= ptr;
        found_nonce <= nonce;
      end
    end
  end

  assign rd_ptr     = ptr;
  assign bloque_out = {blk_q, nonce};

endmodule
